// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: segment decode and KMP next-state.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_LEN = 16;
  localparam logic [7:0]  SEG_BLANK   = 8'h00;

  // Hex nibble to active-high segments, a=bit7 .. g=bit1, dp=bit0 always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'b1111_1100;
      4'h1: seg = 8'b0110_0000;
      4'h2: seg = 8'b1101_1010;
      4'h3: seg = 8'b1111_0010;
      4'h4: seg = 8'b0110_0110;
      4'h5: seg = 8'b1011_0110;
      4'h6: seg = 8'b1011_1110;
      4'h7: seg = 8'b1110_0000;
      4'h8: seg = 8'b1111_1110;
      4'h9: seg = 8'b1111_0110;
      4'hA: seg = 8'b1110_1110;
      4'hB: seg = 8'b0011_1110;
      4'hC: seg = 8'b1001_1100;
      4'hD: seg = 8'b0111_1010;
      4'hE: seg = 8'b1001_1110;
      default: seg = 8'b1000_1110;
    endcase
    return seg;
  endfunction

  // Next state from Sk on input b: longest pattern prefix that is a suffix of
  // (first k pattern bits, b), capped below len; a full match goes to S0 when
  // overlap is off. Pattern bit len-1 is the first one received.
  function automatic int unsigned kmp_next(input logic [MAX_PAT_LEN-1:0] pat,
                                           input int unsigned len,
                                           input int unsigned k,
                                           input logic b,
                                           input bit overlap);
    int unsigned res;
    int unsigned lmax;
    int unsigned pos;
    bit          ok;
    logic        rx;
    res  = 0;
    lmax = (k + 1 < len) ? k + 1 : len - 1;
    for (int unsigned l = 1; l <= lmax; l++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < l; j++) begin
        pos = k + 1 - l + j;
        rx  = (pos == k) ? b : pat[4'(len - 1 - pos)];
        if (rx != pat[4'(len - 1 - j)]) ok = 1'b0;
      end
      if (ok) res = l;
    end
    if ((k == len - 1) && (b == pat[0]) && !overlap) res = 0;
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver: digit 0 shows the state, digits 1..4 the counter nibbles.
module seg7_scan
  import seq_det_pkg::*;
#(
  parameter int unsigned DIGIT       = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state_nib,
  input  logic [3:0][3:0]  cnt_nib,
  output logic [DIGIT-1:0] digit,
  output logic [7:0]       abcdefgh
);

  localparam int unsigned IW = $clog2(DIGIT);
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] scan_idx_nxt;
  logic          scan_step;
  logic [7:0]    seg_nxt;

  // Scan advance and segment pattern for the digit that becomes active next cycle.
  always_comb begin
    scan_step    = (refresh_cnt == RW'(REFRESH_DIV - 1));
    scan_idx_nxt = scan_idx;
    if (scan_step) begin
      scan_idx_nxt = (scan_idx == IW'(DIGIT - 1)) ? '0 : scan_idx + IW'(1);
    end
    seg_nxt = SEG_BLANK;
    if (scan_idx_nxt == '0) begin
      seg_nxt = hex_to_seg(state_nib);
    end else if (32'(scan_idx_nxt) <= 32'd4) begin
      seg_nxt = hex_to_seg(cnt_nib[2'(scan_idx_nxt - IW'(1))]);
    end
  end

  // Digit select and segments are registered together so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      digit       <= DIGIT'(1);
      abcdefgh    <= hex_to_seg(4'h0);
    end else begin
      refresh_cnt <= scan_step ? '0 : refresh_cnt + RW'(1);
      scan_idx    <= scan_idx_nxt;
      digit       <= DIGIT'(1) << scan_idx_nxt;
      abcdefgh    <= seg_nxt;
    end
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Serial Mealy pattern detector with match counter and scanned hex display.
module mealy_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN     = 4'b1011,
  parameter bit                   OVERLAP     = 1'b1,
  parameter int unsigned          DIGIT       = 4,
  parameter int unsigned          REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       din,
  input  logic                       clr_cnt,
  output logic                       match,
  output logic [$clog2(PAT_LEN)-1:0] state,
  output logic [15:0]                match_cnt,
  output logic [7:0]                 abcdefgh,
  output logic [DIGIT-1:0]           digit
);

  localparam int unsigned SW = $clog2(PAT_LEN);

  logic [SW-1:0] nxt_d0 [PAT_LEN];
  logic [SW-1:0] nxt_d1 [PAT_LEN];
  logic [SW-1:0] state_nxt;

  // Transition table fixed at elaboration from PATTERN.
  for (genvar k = 0; k < PAT_LEN; k++) begin : g_tbl
    localparam int unsigned N0 = kmp_next(MAX_PAT_LEN'(PATTERN), PAT_LEN, k, 1'b0, OVERLAP);
    localparam int unsigned N1 = kmp_next(MAX_PAT_LEN'(PATTERN), PAT_LEN, k, 1'b1, OVERLAP);
    assign nxt_d0[k] = SW'(N0);
    assign nxt_d1[k] = SW'(N1);
  end

  // Mealy output: last pattern bit arriving while in the final state.
  assign match = en && (state == SW'(PAT_LEN - 1)) && (din == PATTERN[0]);

  // Next state: table lookup on a strobed bit, otherwise hold.
  always_comb begin
    state_nxt = state;
    if (en) begin
      state_nxt = din ? nxt_d1[state] : nxt_d0[state];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= '0;
    else     state <= state_nxt;
  end

  // Match counter; clear wins over a coincident match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          match_cnt <= '0;
    else if (clr_cnt) match_cnt <= '0;
    else if (match)   match_cnt <= match_cnt + 16'd1;
  end

  seg7_scan #(
    .DIGIT       (DIGIT),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .state_nib (4'(state)),
    .cnt_nib   (match_cnt),
    .digit     (digit),
    .abcdefgh  (abcdefgh)
  );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: two detectors (overlap / non-overlap) driven with identical vectors.
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;

  logic        m_ov, m_no;
  logic [1:0]  s_ov, s_no;
  logic [15:0] c_ov, c_no;
  logic [7:0]  seg_ov, seg_no;
  logic [3:0]  dig_ov, dig_no;

  always #5 clk = ~clk;

  mealy_seq_detector #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .DIGIT(4), .REFRESH_DIV(4)
  ) dut_ov (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .match(m_ov), .state(s_ov), .match_cnt(c_ov), .abcdefgh(seg_ov), .digit(dig_ov)
  );

  mealy_seq_detector #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .DIGIT(4), .REFRESH_DIV(4)
  ) dut_no (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .match(m_no), .state(s_no), .match_cnt(c_no), .abcdefgh(seg_no), .digit(dig_no)
  );

  typedef struct {
    bit          chk_disp;
    logic        m1;
    logic [1:0]  s1;
    logic [15:0] c1;
    logic        m0;
    logic [1:0]  s0;
    logic [15:0] c0;
    logic [3:0]  dig;
    logic [7:0]  seg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tick = 0;
  logic vec_valid = 1'b0;

  // Drive one vector after the active edge and queue what must be seen before the next edge.
  task automatic step(input int r, input int e, input int d, input int c,
                      input int m1, input int s1, input int c1,
                      input int m0, input int s0, input int c0,
                      input int disp, input int seg_e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = 1'(r); en = 1'(e); din = 1'(d); clr_cnt = 1'(c);
    tick++;
    x.chk_disp = (disp != 0);
    x.m1 = 1'(m1); x.s1 = 2'(s1); x.c1 = 16'(c1);
    x.m0 = 1'(m0); x.s0 = 2'(s0); x.c0 = 16'(c0);
    x.dig = (r != 0) ? 4'b0001 : 4'(1 << ((tick / 4) % 4));
    x.seg = 8'(seg_e);
    sb.push_back(x);
    vec_valid = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d, t=%0t): got %0h, expected %0h", nm, n_vec, $time, act, exp);
    end
  endtask

  // Monitor: pop one expectation per presented vector, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t x;
    if (vec_valid) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow at t=%0t", $time);
      end else begin
        x = sb.pop_front();
        n_vec++;
        chk("match_ov", 16'(m_ov), 16'(x.m1));
        chk("state_ov", 16'(s_ov), 16'(x.s1));
        chk("cnt_ov",   c_ov,      x.c1);
        chk("match_no", 16'(m_no), 16'(x.m0));
        chk("state_no", 16'(s_no), 16'(x.s0));
        chk("cnt_no",   c_no,      x.c0);
        if (x.chk_disp) begin
          chk("digit_ov", 16'(dig_ov), 16'(x.dig));
          chk("seg_ov",   16'(seg_ov), 16'(x.seg));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    n_bad++;
    $display("FAIL watchdog_timeout at t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : stim
    // Reset held: everything at its reset value, digit 0 showing '0'.
    step(1, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 8'hFC);
    step(1, 1, 1, 0,  0, 0, 0,  0, 0, 0,  1, 8'hFC);
    // Release, then 20 idle cycles with din toggling: scan advances every 4 clocks.
    tick = -1;
    step(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 8'hFC);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, i % 2, 0,  0, 0, 0,  0, 0, 0,  1, 8'hFC);
    end

    // 1,0,1,1,0,1,1: overlap matches twice, non-overlap once.
    step(0, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0);
    step(0, 1, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
    step(0, 1, 1, 0,  0, 2, 0,  0, 2, 0,  0, 0);
    step(0, 1, 1, 0,  1, 3, 0,  1, 3, 0,  0, 0);
    step(0, 1, 0, 0,  0, 1, 1,  0, 0, 1,  0, 0);
    step(0, 1, 1, 0,  0, 2, 1,  0, 0, 1,  0, 0);
    step(0, 1, 1, 0,  1, 3, 1,  0, 1, 1,  0, 0);

    // en=0 for 20 cycles: nothing moves; display shows state 1 and count 2.
    for (int i = 0; i < 20; i++) begin
      int t;
      int idx;
      int se;
      t   = tick + 1;
      idx = (t / 4) % 4;
      se  = (idx == 0) ? 8'h60 : (idx == 1) ? 8'hDA : 8'hFC;
      step(0, 0, i % 2, 0,  0, 1, 2,  0, 1, 1,  (t >= 29) ? 1 : 0, se);
    end

    // Build the overlap count up to 5, then clear on the cycle of a match.
    step(0, 1, 0, 0,  0, 1, 2,  0, 1, 1,  0, 0);
    step(0, 1, 1, 0,  0, 2, 2,  0, 2, 1,  0, 0);
    step(0, 1, 1, 0,  1, 3, 2,  1, 3, 1,  0, 0);
    step(0, 1, 0, 0,  0, 1, 3,  0, 0, 2,  0, 0);
    step(0, 1, 1, 0,  0, 2, 3,  0, 0, 2,  0, 0);
    step(0, 1, 1, 0,  1, 3, 3,  0, 1, 2,  0, 0);
    step(0, 1, 0, 0,  0, 1, 4,  0, 1, 2,  0, 0);
    step(0, 1, 1, 0,  0, 2, 4,  0, 2, 2,  0, 0);
    step(0, 1, 1, 0,  1, 3, 4,  1, 3, 2,  0, 0);
    step(0, 1, 0, 0,  0, 1, 5,  0, 0, 3,  0, 0);
    step(0, 1, 1, 0,  0, 2, 5,  0, 0, 3,  0, 0);
    step(0, 1, 1, 1,  1, 3, 5,  0, 1, 3,  0, 0);
    step(0, 0, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);

    // Reach S3, confirm en=0 suppresses match, then reset mid-cycle.
    step(0, 1, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
    step(0, 1, 1, 0,  0, 2, 0,  0, 2, 0,  0, 0);
    step(0, 0, 1, 0,  0, 3, 0,  0, 3, 0,  0, 0);
    step(1, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    // Detection restarts from S0: 1,0,1,1 gives exactly one match.
    step(0, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0);
    step(0, 1, 0, 0,  0, 1, 0,  0, 1, 0,  0, 0);
    step(0, 1, 1, 0,  0, 2, 0,  0, 2, 0,  0, 0);
    step(0, 1, 1, 0,  1, 3, 0,  1, 3, 0,  0, 0);
    step(0, 0, 0, 0,  0, 1, 1,  0, 0, 1,  0, 0);

    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
